// File: rtl/debug_link_pkg.sv
// Constants, FSM state type and checksum shared by both ends of the CPU
// debug-port serial link.
package debug_link_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         PORT_COUNT    = 7;
  localparam int         FRAME_BYTES   = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_e;

  // Plain 8-bit wrapping sum of the captured debug bytes.
  function automatic logic [7:0] frame_checksum(input logic [PORT_COUNT-1:0][7:0] b);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      s = s + b[i];
    end
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A new byte may be accepted in IDLE or on the last
// baud cycle of a stop bit, so consecutive bytes go out with no idle gap.
module uart_tx_byte
  import debug_link_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       stop_end_o,
  output logic       tx_o
);

  localparam int             BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);

  uart_state_e   state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          tick;
  logic          load;

  assign tick       = (baud_q == BAUD_LAST);
  assign stop_end_o = (state_q == S_STOP) && tick;
  assign ready_o    = (state_q == S_IDLE) || stop_end_o;
  assign load       = valid_i && ready_o;
  assign tx_o       = tx_q;

  // Bit-level sequencer; tx is registered so each bit starts on a clock edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          tx_q   <= 1'b1;
          if (valid_i) begin
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            baud_q <= '0;
            bit_q  <= '0;
            if (valid_i) begin
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Shift register: loaded on handshake, shifted right as each data bit ends.
  always_ff @(posedge clk) begin
    if (load) begin
      shift_q <= data_i;
    end else if ((state_q == S_DATA) && tick) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Captures the seven CPU debug ports on a snapshot strobe and streams them
// as a 9-byte frame: sync byte, ports 1..7, 8-bit wrapping checksum.
module debug_uart_tx
  import debug_link_pkg::*;
#(
  parameter int         CLK_DIV   = 434,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       snapshot,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       dropped
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  logic                       busy_q;
  logic                       frame_done_q;
  logic                       dropped_q;
  logic [3:0]                 idx_q;
  logic [3:0]                 idx_d;
  // Entries 0..6 hold ports 1..7, entry 7 holds the checksum, so the byte
  // following frame index n is always bytes_q[n].
  logic [7:0][7:0]            bytes_q;
  logic [PORT_COUNT-1:0][7:0] ports_in;
  logic                       accept;
  logic                       byte_valid;
  logic [7:0]                 byte_data;
  logic                       byte_ready;
  logic                       stop_end;
  logic                       last_done;

  assign ports_in  = {debug_port7, debug_port6, debug_port5, debug_port4,
                      debug_port3, debug_port2, debug_port1};
  assign accept    = snapshot && !busy_q;
  assign last_done = busy_q && stop_end && (idx_q == LAST_IDX);

  // Next byte offered to the serialiser: sync when idle, else the one after idx_q.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = SYNC_BYTE;
    idx_d      = idx_q;
    if (!busy_q) begin
      byte_valid = snapshot;
      byte_data  = SYNC_BYTE;
      if (snapshot) begin
        idx_d = '0;
      end
    end else begin
      byte_valid = (idx_q != LAST_IDX);
      byte_data  = bytes_q[idx_q[2:0]];
      if (byte_valid && byte_ready) begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  // Frame control: busy window, completion and drop pulses, byte index.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      dropped_q    <= 1'b0;
      idx_q        <= '0;
    end else begin
      idx_q        <= idx_d;
      frame_done_q <= last_done;
      dropped_q    <= snapshot && busy_q;
      if (accept) begin
        busy_q <= 1'b1;
      end else if (last_done) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Port latches and checksum, captured only on the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      bytes_q[6:0] <= ports_in;
      bytes_q[7]   <= frame_checksum(ports_in);
    end
  end

  uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_byte (
    .clk        (clk),
    .nreset     (nreset),
    .data_i     (byte_data),
    .valid_i    (byte_valid),
    .ready_o    (byte_ready),
    .stop_end_o (stop_end),
    .tx_o       (tx)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: the expected line waveform is built from the
// frame bytes (sync, ports, sum mod 256) expanded into 8N1 bits.
module tb_debug_uart_tx;

  logic            clk = 1'b0;
  logic            nreset = 1'b1;
  logic            snapshot = 1'b0;
  logic [6:0][7:0] ports = '0;
  logic            sel = 1'b0;

  logic tx_a, busy_a, fd_a, dr_a;
  logic tx_b, busy_b, fd_b, dr_b;
  logic tx_m, busy_m, fd_m, dr_m;

  int nvec = 0;
  int nbad = 0;

  typedef struct {
    logic [6:0][7:0] p;
    logic [7:0]      cks;
    int              chg_at;
    int              drop_at;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  debug_uart_tx #(.CLK_DIV(4)) dut_a (
    .clk(clk), .nreset(nreset), .snapshot(snapshot),
    .debug_port1(ports[0]), .debug_port2(ports[1]), .debug_port3(ports[2]),
    .debug_port4(ports[3]), .debug_port5(ports[4]), .debug_port6(ports[5]),
    .debug_port7(ports[6]),
    .tx(tx_a), .busy(busy_a), .frame_done(fd_a), .dropped(dr_a)
  );

  debug_uart_tx #(.CLK_DIV(2)) dut_b (
    .clk(clk), .nreset(nreset), .snapshot(snapshot),
    .debug_port1(ports[0]), .debug_port2(ports[1]), .debug_port3(ports[2]),
    .debug_port4(ports[3]), .debug_port5(ports[4]), .debug_port6(ports[5]),
    .debug_port7(ports[6]),
    .tx(tx_b), .busy(busy_b), .frame_done(fd_b), .dropped(dr_b)
  );

  assign tx_m   = sel ? tx_b   : tx_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign fd_m   = sel ? fd_b   : fd_a;
  assign dr_m   = sel ? dr_b   : dr_a;

  function automatic int dv();
    return sel ? 2 : 4;
  endfunction

  // Line level for bit j of a frame: 10 bits per byte, start 0, LSB first, stop 1.
  function automatic logic exp_bit(input logic [8:0][7:0] fb, input int j);
    int by;
    int pos;
    by  = j / 10;
    pos = j % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return fb[by][pos-1];
  endfunction

  function automatic logic [7:0] model_sum(input logic [6:0][7:0] p);
    int s;
    s = 0;
    for (int i = 0; i < 7; i++) s += int'(p[i]);
    return 8'(s % 256);
  endfunction

  task automatic chk(input string nm, input int k, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s at k=%0d: got %b want %b", nm, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 nreset = 1'b0;
    snapshot = 1'b0;
    repeat (3) tick();
    nreset = 1'b1;
    tick();
  endtask

  // Sends one frame and checks every cycle from the acceptance edge (k=0)
  // to the frame_done cycle (k=90*D). chain leaves the caller in the
  // frame_done cycle so a following call is sampled there.
  task automatic run_frame(input logic [6:0][7:0] p, input logic [7:0] cks,
                           input int chg_at, input int drop_at,
                           input int abort_at, input bit chain);
    logic [8:0][7:0] fb;
    int d;
    int n;
    d = dv();
    n = 90 * d;
    fb[0] = 8'hA5;
    for (int i = 0; i < 7; i++) fb[i+1] = p[i];
    fb[8] = cks;
    ports    = p;
    snapshot = 1'b1;
    for (int k = 0; k <= n; k++) begin
      tick();
      chk("tx", k, tx_m, (k < n) ? exp_bit(fb, k / d) : 1'b1);
      chk("busy", k, busy_m, k < n);
      chk("frame_done", k, fd_m, k == n);
      chk("dropped", k, dr_m, (drop_at >= 0) && (k == drop_at));
      snapshot = (k + 1 == drop_at);
      if (k == chg_at) ports = {7{8'h55}};
      if (k == abort_at) begin
        #2 nreset = 1'b0;
        #1;
        chk("abort_tx", k, tx_m, 1'b1);
        chk("abort_busy", k, busy_m, 1'b0);
        chk("abort_frame_done", k, fd_m, 1'b0);
        chk("abort_dropped", k, dr_m, 1'b0);
        snapshot = 1'b0;
        repeat (2) tick();
        nreset = 1'b1;
        tick();
        return;
      end
    end
    if (!chain) begin
      tick();
      chk("post_tx", n + 1, tx_m, 1'b1);
      chk("post_busy", n + 1, busy_m, 1'b0);
      chk("post_frame_done", n + 1, fd_m, 1'b0);
      chk("post_dropped", n + 1, dr_m, 1'b0);
    end
  endtask

  initial begin
    logic [6:0][7:0] rp;
    logic [6:0][7:0] rp2;

    // Fixed vectors: ascending ports, latch isolation with a drop, wrap cases.
    for (int i = 0; i < 7; i++) begin
      tbl[0].p[i] = 8'(i + 1);
      tbl[1].p[i] = 8'(i + 1);
      tbl[2].p[i] = 8'hFF;
      tbl[3].p[i] = 8'h00;
    end
    tbl[4].p = {8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    tbl[0].cks = 8'h1C; tbl[0].chg_at = -1; tbl[0].drop_at = -1;
    tbl[1].cks = 8'h1C; tbl[1].chg_at = 10; tbl[1].drop_at = 20;
    tbl[2].cks = 8'hF9; tbl[2].chg_at = -1; tbl[2].drop_at = -1;
    tbl[3].cks = 8'h00; tbl[3].chg_at = -1; tbl[3].drop_at = 100;
    tbl[4].cks = 8'hFE; tbl[4].chg_at = 0;  tbl[4].drop_at = 359;

    // Reset state and quiet line after release.
    #2 nreset = 1'b0;
    repeat (3) tick();
    chk("rst_tx", 0, tx_m, 1'b1);
    chk("rst_busy", 0, busy_m, 1'b0);
    chk("rst_frame_done", 0, fd_m, 1'b0);
    chk("rst_dropped", 0, dr_m, 1'b0);
    nreset = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("idle_tx", k, tx_m, 1'b1);
      chk("idle_busy", k, busy_m, 1'b0);
    end

    for (int v = 0; v < 5; v++) begin
      run_frame(tbl[v].p, tbl[v].cks, tbl[v].chg_at, tbl[v].drop_at, -1, 1'b0);
    end

    // Random ports, random port changes and drop strobes.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 7; i++) rp[i] = 8'($urandom_range(0, 255));
      run_frame(rp, model_sum(rp), int'($urandom_range(0, 359)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 359)) : -1,
                -1, r[0]);
    end
    tick();

    // Reset in the start bit of byte 3, then a clean frame.
    run_frame(tbl[0].p, 8'h1C, -1, -1, 30 * 4 + 1, 1'b0);
    run_frame(tbl[0].p, 8'h1C, -1, -1, -1, 1'b0);

    // Back-to-back on the CLK_DIV=2 instance.
    do_reset();
    sel = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rp[i]  = 8'($urandom_range(0, 255));
      rp2[i] = 8'($urandom_range(0, 255));
    end
    run_frame(rp, model_sum(rp), -1, -1, -1, 1'b1);
    run_frame(rp2, model_sum(rp2), -1, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
